sonic_sensor_responder: RTL and testbench

Behavioural responder for the single-wire ultrasonic ranging protocol: the sensor end of the link. It watches the shared `sig` line for a host trigger pulse, waits the sensor hold-off, drives an echo pulse whose width encodes a programmed distance, then enforces a guard interval. It sits on the FPGA as a stand-in for the physical sensor in loopback tests and demo builds, wired to the same `sig` net as the host controller.

---
 rtl/sonic_pkg.sv | 33 +++
 rtl/sonic_sync.sv | 27 ++
 rtl/sonic_sensor_responder.sv | 136 +++++++++++++
 tb/tb_sonic_sensor_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared definitions for the single-wire ultrasonic ranging link.
// Holds the responder FSM state type and the two default timing sets.
// Used by the responder and by the host controller bench.
//
// Build option: SONIC_RESP_FAST_SIM_EN
//   defined   -> short timing defaults for quick simulations
//   undefined -> real-sensor timing defaults (100 MHz clock)
package sonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_ECHO    = 3'd3,
    ST_GUARD   = 3'd4,
    ST_STUCK   = 3'd5
  } sonic_state_e;

`ifdef SONIC_RESP_FAST_SIM_EN
  localparam logic [31:0] SONIC_TRIG_MIN = 32'd5;
  localparam logic [31:0] SONIC_TRIG_MAX = 32'd1000;
  localparam logic [31:0] SONIC_HOLDOFF  = 32'd750;
  localparam logic [31:0] SONIC_ECHO_MAX = 32'd18500;
  localparam logic [31:0] SONIC_GUARD    = 32'd200;
`else
  localparam logic [31:0] SONIC_TRIG_MIN = 32'd500;
  localparam logic [31:0] SONIC_TRIG_MAX = 32'd100000;
  localparam logic [31:0] SONIC_HOLDOFF  = 32'd75000;
  localparam logic [31:0] SONIC_ECHO_MAX = 32'd1850000;
  localparam logic [31:0] SONIC_GUARD    = 32'd20000;
`endif

endpackage

// File: rtl/sonic_sync.sv
// Two-flop synchronizer for the asynchronous protocol line.
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous reset, active-low
//   d    in  : asynchronous input
//   q    out : synchronized output (two cycles of latency, resets to 0)
module sonic_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;

  // stage p0 captures the raw line, q re-times it into the clock domain
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/sonic_sensor_responder.sv
// Sensor end of the single-wire ultrasonic ranging link. Watches sig for a
// host trigger pulse, waits the hold-off, drives an echo pulse whose width is
// the programmed distance, then ignores the line for a guard interval.
//
// Build option: SONIC_RESP_FAST_SIM_EN (selects short parameter defaults
// through sonic_pkg; behaviour is otherwise identical).
//
// Ports:
//   clk        in    : system clock (100 MHz)
//   rst        in    : synchronous reset, active-low
//   sig        inout : protocol line, driven 1 only while echoing, else Z
//   len_in     in    : echo width to emulate, in cycles
//   len_we     in    : loads len_in into the shadow register
//   busy       out   : high whenever the FSM is not idle
//   echo_done  out   : one-cycle pulse in the first guard cycle
//   trig_err   out   : one-cycle pulse when a trigger is rejected
//   trig_count out   : accepted-trigger count, wraps at 0xFFFF
module sonic_sensor_responder
  import sonic_pkg::*;
#(
  parameter logic [31:0] TRIG_MIN = SONIC_TRIG_MIN,
  parameter logic [31:0] TRIG_MAX = SONIC_TRIG_MAX,
  parameter logic [31:0] HOLDOFF  = SONIC_HOLDOFF,
  parameter logic [31:0] ECHO_MAX = SONIC_ECHO_MAX,
  parameter logic [31:0] GUARD    = SONIC_GUARD
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         sig,
  input  logic [31:0] len_in,
  input  logic        len_we,
  output logic        busy,
  output logic        echo_done,
  output logic        trig_err,
  output logic [15:0] trig_count
);

  sonic_state_e state_q, state_d;
  logic [31:0]  cnt_q;
  logic [31:0]  shadow_q;
  logic [31:0]  len_act_q;
  logic [31:0]  echo_len;
  logic         sig_s;
  logic         accept;
  logic         reject;

  // Echo width: zero still produces a one-cycle pulse, long values clamp.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    if (len == 32'd0) begin
      clamp_len = 32'd1;
    end else if (len > ECHO_MAX) begin
      clamp_len = ECHO_MAX;
    end else begin
      clamp_len = len;
    end
  endfunction

  sonic_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig),
    .q   (sig_s)
  );

  assign echo_len = clamp_len(len_act_q);
  assign busy     = (state_q != ST_IDLE);
  assign sig      = (state_q == ST_ECHO) ? 1'b1 : 1'bz;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sig_s) state_d = ST_TRIG;
      end
      ST_TRIG: begin
        if (cnt_q >= TRIG_MAX) begin
          state_d = ST_STUCK;
          reject  = 1'b1;
        end else if (!sig_s) begin
          if (cnt_q >= TRIG_MIN) begin
            state_d = ST_HOLDOFF;
            accept  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            reject  = 1'b1;
          end
        end
      end
      ST_STUCK: begin
        if (!sig_s) state_d = ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (cnt_q + 32'd1 >= HOLDOFF) state_d = ST_ECHO;
      end
      ST_ECHO: begin
        if (cnt_q + 32'd1 >= echo_len) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (cnt_q + 32'd1 >= GUARD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      shadow_q   <= 32'd0;
      len_act_q  <= 32'd0;
      echo_done  <= 1'b0;
      trig_err   <= 1'b0;
      trig_count <= 16'd0;
    end else begin
      state_q <= state_d;
      // On entering TRIG the high sample seen in IDLE is already counted,
      // so cnt in TRIG equals the number of high cycles seen on the pin.
      if (state_d != state_q) begin
        cnt_q <= (state_d == ST_TRIG) ? 32'd1 : 32'd0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (len_we) shadow_q <= len_in;
      // Non-blocking read of shadow_q: a same-cycle write goes to the next trigger.
      if (accept) begin
        len_act_q  <= shadow_q;
        trig_count <= trig_count + 16'd1;
      end
      echo_done <= (state_q == ST_ECHO) && (state_d == ST_GUARD);
      trig_err  <= reject;
    end
  end

endmodule

// File: tb/tb_sonic_sensor_responder.sv
module tb_sonic_sensor_responder;

  localparam logic [31:0] P_TRIG_MIN = 32'd5;
  localparam logic [31:0] P_TRIG_MAX = 32'd1000;
  localparam logic [31:0] P_HOLDOFF  = 32'd750;
  localparam logic [31:0] P_ECHO_MAX = 32'd18500;
  localparam logic [31:0] P_GUARD    = 32'd200;
  localparam int          ECHO_DELAY = 3 + 750;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_drv = 1'b0;
  logic        len_we = 1'b0;
  logic [31:0] len_in = 32'd0;
  wire         sig_w;
  logic        busy;
  logic        echo_done;
  logic        trig_err;
  logic [15:0] trig_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] shadow_m = 32'd0;
  logic [15:0] count_m  = 16'd0;

  // observations of the last run_trigger call (times relative to trigger release)
  int   obs_first;
  int   obs_hi;
  int   obs_rises;
  int   obs_done;
  int   obs_done_t;
  int   obs_err;
  logic obs_busy_rel;
  bit   obs_timeout;

  assign sig_w = host_drv ? 1'b1 : 1'bz;
  pulldown (sig_w);

  always #5 clk = ~clk;

  sonic_sensor_responder #(
    .TRIG_MIN (P_TRIG_MIN),
    .TRIG_MAX (P_TRIG_MAX),
    .HOLDOFF  (P_HOLDOFF),
    .ECHO_MAX (P_ECHO_MAX),
    .GUARD    (P_GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig_w),
    .len_in     (len_in),
    .len_we     (len_we),
    .busy       (busy),
    .echo_done  (echo_done),
    .trig_err   (trig_err),
    .trig_count (trig_count)
  );

  function automatic logic [31:0] model_len(input logic [31:0] s);
    if (s == 32'd0) return 32'd1;
    if (s > P_ECHO_MAX) return P_ECHO_MAX;
    return s;
  endfunction

  function automatic bit model_accept(input int w);
    return (w >= int'(P_TRIG_MIN)) && (w < int'(P_TRIG_MAX));
  endfunction

  task automatic write_len(input logic [31:0] v);
    @(negedge clk);
    len_in = v;
    len_we = 1'b1;
    @(negedge clk);
    len_we = 1'b0;
    shadow_m = v;
  endtask

  // Host drives a w-cycle trigger, then watches the line until the responder
  // is idle again. Optional len write at negedge wr_t, optional host pulse
  // inside the guard interval.
  task automatic run_trigger(input int w, input int wr_t, input logic [31:0] wr_val,
                             input bit guard_pulse);
    int t;
    bit prev_hi;
    bit hi;
    obs_first = -1; obs_hi = 0; obs_rises = 0; obs_done = 0; obs_done_t = -1;
    obs_err = 0; obs_timeout = 0; obs_busy_rel = 1'bx; prev_hi = 0; t = 0;
    @(negedge clk);
    host_drv = 1'b1;
    forever begin
      @(negedge clk);
      t++;
      hi = !host_drv && (sig_w === 1'b1);
      if (hi) begin
        obs_hi++;
        if (!prev_hi) obs_rises++;
        if (obs_first < 0) obs_first = t - w;
      end
      prev_hi = hi;
      if (echo_done === 1'b1) begin obs_done++; obs_done_t = t - w; end
      if (trig_err === 1'b1) obs_err++;
      if (t == w) obs_busy_rel = busy;
      if (len_we) len_we = 1'b0;
      if (t == w) host_drv = 1'b0;
      if (t == wr_t) begin len_in = wr_val; len_we = 1'b1; end
      if (guard_pulse && obs_done_t >= 0 && t == obs_done_t + w + 5) host_drv = 1'b1;
      if (guard_pulse && obs_done_t >= 0 && t == obs_done_t + w + 15) host_drv = 1'b0;
      if (t >= w + 8 && busy === 1'b0 && !host_drv) break;
      if (t > w + 30000) begin obs_timeout = 1; host_drv = 1'b0; break; end
    end
    len_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (echo_done !== 1'b0) begin errors++; $display("FAIL reset_echo_done got %b want 0", echo_done); end
    checks++; if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err got %b want 0", trig_err); end
    checks++; if (trig_count !== 16'd0) begin errors++; $display("FAIL reset_trig_count got %0d want 0", trig_count); end
    checks++; if (sig_w !== 1'b0) begin errors++; $display("FAIL reset_sig got %b want released", sig_w); end
    rst = 1'b1;
    shadow_m = 32'd0;
    count_m  = 16'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_echo();
    logic [31:0] exp_l;
    write_len(32'd1000);
    exp_l = model_len(shadow_m);
    run_trigger(5, -1, 32'd0, 0);
    count_m++;
    checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", obs_timeout); end
    checks++; if (obs_first !== ECHO_DELAY) begin errors++; $display("FAIL basic_start got %0d want %0d", obs_first, ECHO_DELAY); end
    checks++; if (obs_hi !== int'(exp_l)) begin errors++; $display("FAIL basic_width got %0d want %0d", obs_hi, exp_l); end
    checks++; if (obs_rises !== 1) begin errors++; $display("FAIL basic_rises got %0d want 1", obs_rises); end
    checks++; if (obs_done !== 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", obs_done); end
    checks++; if (obs_done_t !== ECHO_DELAY + int'(exp_l)) begin errors++; $display("FAIL basic_done_time got %0d want %0d", obs_done_t, ECHO_DELAY + int'(exp_l)); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL basic_err got %0d want 0", obs_err); end
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL basic_count got %0d want %0d", trig_count, count_m); end
  endtask

  task automatic test_short_trigger();
    run_trigger(4, -1, 32'd0, 0);
    checks++; if (obs_err !== 1) begin errors++; $display("FAIL short_err got %0d want 1", obs_err); end
    checks++; if (obs_hi !== 0) begin errors++; $display("FAIL short_echo got %0d want 0", obs_hi); end
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL short_count got %0d want %0d", trig_count, count_m); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got %b want 0", busy); end
  endtask

  task automatic test_stuck();
    run_trigger(1200, -1, 32'd0, 0);
    checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL stuck_timeout got %0d want 0", obs_timeout); end
    checks++; if (obs_err !== 1) begin errors++; $display("FAIL stuck_err got %0d want 1", obs_err); end
    checks++; if (obs_busy_rel !== 1'b1) begin errors++; $display("FAIL stuck_busy_held got %b want 1", obs_busy_rel); end
    checks++; if (obs_hi !== 0) begin errors++; $display("FAIL stuck_echo got %0d want 0", obs_hi); end
    checks++; if (obs_done !== 0) begin errors++; $display("FAIL stuck_done got %0d want 0", obs_done); end
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL stuck_count got %0d want %0d", trig_count, count_m); end
  endtask

  task automatic test_len_clamp();
    logic [31:0] vals [2];
    vals[0] = 32'd0;
    vals[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      write_len(vals[i]);
      run_trigger(6, -1, 32'd0, 0);
      count_m++;
      checks++; if (obs_hi !== int'(model_len(shadow_m))) begin errors++; $display("FAIL clamp_width len=%0h got %0d want %0d", vals[i], obs_hi, model_len(shadow_m)); end
      checks++; if (obs_done_t !== ECHO_DELAY + int'(model_len(shadow_m))) begin errors++; $display("FAIL clamp_done_time got %0d want %0d", obs_done_t, ECHO_DELAY + int'(model_len(shadow_m))); end
      checks++; if (trig_count !== count_m) begin errors++; $display("FAIL clamp_count got %0d want %0d", trig_count, count_m); end
    end
  endtask

  task automatic test_shadow_update();
    logic [31:0] used;
    write_len(32'd1000);
    // write 500 in the middle of the echo: current echo keeps the old length
    used = shadow_m;
    run_trigger(5, 5 + 800, 32'd500, 0);
    shadow_m = 32'd500; count_m++;
    checks++; if (obs_hi !== int'(model_len(used))) begin errors++; $display("FAIL shadow_mid_echo got %0d want %0d", obs_hi, model_len(used)); end
    used = shadow_m;
    run_trigger(5, -1, 32'd0, 0);
    count_m++;
    checks++; if (obs_hi !== int'(model_len(used))) begin errors++; $display("FAIL shadow_next got %0d want %0d", obs_hi, model_len(used)); end
    // write on the acceptance cycle itself: old value still used
    used = shadow_m;
    run_trigger(7, 7 + 2, 32'd40, 0);
    shadow_m = 32'd40; count_m++;
    checks++; if (obs_hi !== int'(model_len(used))) begin errors++; $display("FAIL shadow_same_cycle got %0d want %0d", obs_hi, model_len(used)); end
    used = shadow_m;
    run_trigger(7, -1, 32'd0, 0);
    count_m++;
    checks++; if (obs_hi !== int'(model_len(used))) begin errors++; $display("FAIL shadow_after_same got %0d want %0d", obs_hi, model_len(used)); end
  endtask

  task automatic test_guard_ignore();
    write_len(32'd20);
    run_trigger(5, -1, 32'd0, 1);
    count_m++;
    checks++; if (obs_hi !== 20) begin errors++; $display("FAIL guard_width got %0d want 20", obs_hi); end
    checks++; if (obs_rises !== 1) begin errors++; $display("FAIL guard_rises got %0d want 1", obs_rises); end
    checks++; if (obs_err !== 0) begin errors++; $display("FAIL guard_err got %0d want 0", obs_err); end
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL guard_count got %0d want %0d", trig_count, count_m); end
  endtask

  task automatic test_reset_mid_echo();
    write_len(32'd100);
    @(negedge clk);
    host_drv = 1'b1;
    repeat (5) @(negedge clk);
    host_drv = 1'b0;
    repeat (ECHO_DELAY + 10) @(negedge clk);
    checks++; if (sig_w !== 1'b1) begin errors++; $display("FAIL rstmid_in_echo got %b want 1", sig_w); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sig_w !== 1'b0) begin errors++; $display("FAIL rstmid_sig got %b want released", sig_w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (echo_done !== 1'b0) begin errors++; $display("FAIL rstmid_echo_done got %b want 0", echo_done); end
    checks++; if (trig_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", trig_count); end
    rst = 1'b1;
    shadow_m = 32'd0; count_m = 16'd0;
    @(negedge clk);
    write_len(32'd30);
    run_trigger(6, -1, 32'd0, 0);
    count_m++;
    checks++; if (obs_hi !== 30) begin errors++; $display("FAIL rstmid_after_width got %0d want 30", obs_hi); end
    checks++; if (obs_first !== ECHO_DELAY) begin errors++; $display("FAIL rstmid_after_start got %0d want %0d", obs_first, ECHO_DELAY); end
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL rstmid_after_count got %0d want %0d", trig_count, count_m); end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.trig_count = 16'hFFFF;
    #1;
    release dut.trig_count;
    count_m = 16'hFFFF;
    write_len(32'd3);
    run_trigger(5, -1, 32'd0, 0);
    count_m = count_m + 16'd1;
    checks++; if (trig_count !== count_m) begin errors++; $display("FAIL wrap_count got %0d want %0d", trig_count, count_m); end
  endtask

  task automatic test_random();
    int w;
    bit acc;
    logic [31:0] used;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) write_len(32'($urandom_range(0, 60)));
      w = $urandom_range(1, 10);
      acc = model_accept(w);
      used = shadow_m;
      run_trigger(w, -1, 32'd0, 0);
      if (acc) count_m++;
      checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL rand_timeout w=%0d got %0d want 0", w, obs_timeout); end
      checks++; if (obs_hi !== (acc ? int'(model_len(used)) : 0)) begin errors++; $display("FAIL rand_width w=%0d got %0d want %0d", w, obs_hi, acc ? int'(model_len(used)) : 0); end
      checks++; if (obs_err !== (acc ? 0 : 1)) begin errors++; $display("FAIL rand_err w=%0d got %0d want %0d", w, obs_err, acc ? 0 : 1); end
      checks++; if (obs_done !== (acc ? 1 : 0)) begin errors++; $display("FAIL rand_done w=%0d got %0d want %0d", w, obs_done, acc ? 1 : 0); end
      checks++; if (trig_count !== count_m) begin errors++; $display("FAIL rand_count w=%0d got %0d want %0d", w, trig_count, count_m); end
      if (acc) begin
        checks++; if (obs_first !== ECHO_DELAY) begin errors++; $display("FAIL rand_start w=%0d got %0d want %0d", w, obs_first, ECHO_DELAY); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_echo();
    test_short_trigger();
    test_stuck();
    test_len_clamp();
    test_shadow_update();
    test_guard_ignore();
    test_reset_mid_echo();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
